// File: rtl/fetch_sequencer.sv
// Fetch sequencer: walks the instruction ROM and feeds a one-entry IF/ID buffer.
// Latency: instruction at address A appears on out_instr one clock after pc==A.
// Backpressure: out_valid && !out_ready holds pc and the buffer; redirect flushes.
// Optional macro FETCH_LOOP_EN: wrap pc to 0 after the last word instead of draining.
module fetch_sequencer #(
  parameter int ADDR_W   = 3,
  parameter int INSTR_W  = 32,
  parameter int PROG_LEN = 6
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_instr,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] out_instr,
  output logic [ADDR_W-1:0]  out_pc,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic               busy,
  output logic               done
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_PC = ADDR_W'(PROG_LEN - 1);

  state_t               r_state;
  state_t               w_state_nxt;
  logic [ADDR_W-1:0]    r_pc;
  logic                 r_out_valid;
  logic [INSTR_W-1:0]   r_out_instr;
  logic [ADDR_W-1:0]    r_out_pc;

  logic w_start;
  logic w_redir;
  logic w_redir_in;
  logic w_load;
  logic w_at_end;
  logic w_drain_acc;

  // Redirect wins over both load and stall; start only counts when not running.
  assign w_start     = start && (r_state == S_IDLE || r_state == S_DONE);
  assign w_redir     = redirect_valid && (r_state == S_FETCH || r_state == S_DRAIN);
  assign w_redir_in  = (redirect_pc <= LAST_PC);
  assign w_load      = (r_state == S_FETCH) && (!r_out_valid || out_ready) && !redirect_valid;
  assign w_at_end    = (r_pc == LAST_PC);
  assign w_drain_acc = (r_state == S_DRAIN) && r_out_valid && out_ready && !redirect_valid;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) w_state_nxt = S_FETCH;
      end
      S_FETCH: begin
        if (redirect_valid) begin
          w_state_nxt = w_redir_in ? S_FETCH : S_DONE;
        end else if (w_load && w_at_end) begin
`ifdef FETCH_LOOP_EN
          w_state_nxt = S_FETCH;
`else
          w_state_nxt = S_DRAIN;
`endif
        end
      end
      S_DRAIN: begin
        if (redirect_valid)  w_state_nxt = w_redir_in ? S_FETCH : S_DONE;
        else if (w_drain_acc) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        if (start) w_state_nxt = S_FETCH;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State-decoded status outputs
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (r_state)
      S_FETCH, S_DRAIN: busy = 1'b1;
      S_DONE:           done = 1'b1;
      default: ;
    endcase
  end

  // Program counter: restart, redirect target, or advance on each issued load
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc <= '0;
    end else if (w_start) begin
      r_pc <= '0;
    end else if (w_redir) begin
      // An out-of-range target ends the program; pc is left where it was.
      if (w_redir_in) r_pc <= redirect_pc;
    end else if (w_load) begin
      if (!w_at_end) begin
        r_pc <= r_pc + ADDR_W'(1);
      end else begin
`ifdef FETCH_LOOP_EN
        r_pc <= '0;
`else
        r_pc <= r_pc;
`endif
      end
    end
  end

  // IF/ID buffer: flush on redirect, fill on load, empty once the last word is taken
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_instr <= '0;
      r_out_pc    <= '0;
    end else if (w_redir) begin
      r_out_valid <= 1'b0;
    end else if (w_load) begin
      r_out_valid <= 1'b1;
      r_out_instr <= imem_instr;
      r_out_pc    <= r_pc;
    end else if (w_drain_acc) begin
      r_out_valid <= 1'b0;
    end
  end

  assign imem_addr = r_pc;
  assign out_valid = r_out_valid;
  assign out_instr = r_out_instr;
  assign out_pc    = r_out_pc;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer with a 6-word ROM model.
// Inputs change 1ns after the rising edge; outputs are checked at that point.
// Handshakes are counted on the falling edge.
module tb_fetch_sequencer;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [2:0]  imem_addr;
  logic [31:0] imem_instr;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [2:0]  out_pc;
  logic        redirect_valid;
  logic [2:0]  redirect_pc;
  logic        busy;
  logic        done;

  logic [31:0] rom [0:7];
  int n_checks;
  int n_errs;
  int hs;
  int hs_base;

  fetch_sequencer #(.ADDR_W(3), .INSTR_W(32), .PROG_LEN(6)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .imem_addr      (imem_addr),
    .imem_instr     (imem_instr),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .busy           (busy),
    .done           (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign imem_instr = rom[imem_addr];

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready && !redirect_valid) hs++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_errs   = 0;
    hs       = 0;
    rom[0] = 32'h1111_0000; rom[1] = 32'h2222_0001; rom[2] = 32'h3333_0002;
    rom[3] = 32'h4444_0003; rom[4] = 32'h5555_0004; rom[5] = 32'h6666_0005;
    rom[6] = 32'hDEAD_0006; rom[7] = 32'hDEAD_0007;
    rst_n = 1'b0; start = 1'b0; out_ready = 1'b1;
    redirect_valid = 1'b0; redirect_pc = 3'd0;

    // Reset state
    #12;
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_instr", out_instr, 32'd0);
    chk("rst_pc", {29'd0, out_pc}, 32'd0);
    chk("rst_addr", {29'd0, imem_addr}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    rst_n = 1'b1;
    tick();

    // Start from IDLE
    hs_base = hs;
    do_start();
    chk("start_busy", {31'd0, busy}, 32'd1);
    chk("start_addr", {29'd0, imem_addr}, 32'd0);
    chk("start_valid", {31'd0, out_valid}, 32'd0);

`ifdef FETCH_LOOP_EN
    // Continuous loop: 14 handshakes wrap 0..5,0..5,0,1
    for (int i = 0; i < 14; i++) begin
      tick();
      chk("loop_pc", {29'd0, out_pc}, i % 6);
      chk("loop_instr", out_instr, rom[i % 6]);
      chk("loop_done", {31'd0, done}, 32'd0);
    end
    tick();
    chk("loop_hs", hs - hs_base, 32'd14);
    chk("loop_pc_next", {29'd0, out_pc}, 32'd2);
    // Leave the loop through an out-of-range redirect
    redirect_valid = 1'b1; redirect_pc = 3'd6;
    tick();
    redirect_valid = 1'b0;
    chk("loop_exit_done", {31'd0, done}, 32'd1);
    chk("loop_exit_valid", {31'd0, out_valid}, 32'd0);
`else
    // Straight run with out_ready=1
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("run_valid", {31'd0, out_valid}, 32'd1);
      chk("run_pc", {29'd0, out_pc}, i);
      chk("run_instr", out_instr, rom[i]);
      chk("run_done", {31'd0, done}, 32'd0);
    end
    chk("drain_busy", {31'd0, busy}, 32'd1);
    chk("drain_addr", {29'd0, imem_addr}, 32'd5);
    tick();
    chk("end_valid", {31'd0, out_valid}, 32'd0);
    chk("end_done", {31'd0, done}, 32'd1);
    chk("end_busy", {31'd0, busy}, 32'd0);
    tick();
    chk("end_done2", {31'd0, done}, 32'd1);
    chk("run_hs", hs - hs_base, 32'd6);

    // Restart from DONE, then stall at out_pc=2
    do_start();
    chk("restart_done", {31'd0, done}, 32'd0);
    chk("restart_busy", {31'd0, busy}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("pre_stall_pc", {29'd0, out_pc}, i);
    end
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("stall_valid", {31'd0, out_valid}, 32'd1);
      chk("stall_pc", {29'd0, out_pc}, 32'd2);
      chk("stall_instr", out_instr, rom[2]);
      chk("stall_addr", {29'd0, imem_addr}, 32'd3);
    end
    out_ready = 1'b1;
    for (int i = 3; i < 6; i++) begin
      tick();
      chk("resume_pc", {29'd0, out_pc}, i);
      chk("resume_instr", out_instr, rom[i]);
    end
    tick();
    chk("resume_done", {31'd0, done}, 32'd1);

    // In-range redirect while out_pc=3 is being accepted
    do_start();
    for (int i = 0; i < 4; i++) tick();
    chk("pre_redir_pc", {29'd0, out_pc}, 32'd3);
    redirect_valid = 1'b1; redirect_pc = 3'd1;
    tick();
    redirect_valid = 1'b0;
    chk("redir_flush", {31'd0, out_valid}, 32'd0);
    chk("redir_addr", {29'd0, imem_addr}, 32'd1);
    for (int i = 1; i < 6; i++) begin
      tick();
      chk("redir_valid", {31'd0, out_valid}, 32'd1);
      chk("redir_pc", {29'd0, out_pc}, i);
      chk("redir_instr", out_instr, rom[i]);
    end
    tick();
    chk("redir_end_done", {31'd0, done}, 32'd1);
`endif

    // Out-of-range redirect during FETCH
    do_start();
    tick();
    tick();
    chk("oor_pre_pc", {29'd0, out_pc}, 32'd1);
    redirect_valid = 1'b1; redirect_pc = 3'd7;
    tick();
    redirect_valid = 1'b0;
    chk("oor_valid", {31'd0, out_valid}, 32'd0);
    chk("oor_done", {31'd0, done}, 32'd1);
    chk("oor_busy", {31'd0, busy}, 32'd0);
    // Redirect in DONE is ignored
    redirect_valid = 1'b1; redirect_pc = 3'd2;
    tick();
    redirect_valid = 1'b0;
    chk("done_redir_done", {31'd0, done}, 32'd1);
    chk("done_redir_valid", {31'd0, out_valid}, 32'd0);

    // Async reset in the middle of a stall
    do_start();
    tick();
    tick();
    out_ready = 1'b0;
    tick();
    tick();
    chk("pre_arst_pc", {29'd0, out_pc}, 32'd1);
    chk("pre_arst_valid", {31'd0, out_valid}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", {31'd0, out_valid}, 32'd0);
    chk("arst_addr", {29'd0, imem_addr}, 32'd0);
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_done", {31'd0, done}, 32'd0);
    chk("arst_pc", {29'd0, out_pc}, 32'd0);
    chk("arst_instr", out_instr, 32'd0);
    rst_n = 1'b1;
    out_ready = 1'b1;
    tick();
    chk("post_arst_busy", {31'd0, busy}, 32'd0);
    do_start();
    tick();
    chk("post_arst_pc", {29'd0, out_pc}, 32'd0);
    chk("post_arst_instr", out_instr, rom[0]);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
